// File: rtl/merge_sync_sink.sv
// Clocked sink for the two-way self-timed merge: captures each drive pulse into clk,
// buffers tokens in a small FIFO, and returns o_free only when buffer space exists.
module merge_sync_sink #(
  parameter int DATA_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int FREE_PULSE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_drive,
  input  logic [2*DATA_WIDTH-1:0]          i_data,
  output logic                             o_free,
  output logic                             o_valid,
  output logic [2*DATA_WIDTH-1:0]          o_data,
  input  logic                             i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count,
  output logic                             o_proto_err
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FREE_PULSE_CYCLES + 1);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] FREE_LAST = FW'(FREE_PULSE_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    FREE       = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          tog_q;
  logic          s1_q, s2_q, s3_q;
  logic [PW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          err_q, err_d;
  logic          valid_q, free_q;
  logic          evt, push, pop;
  logic [CW:0]   post_cnt;

  // The drive pulse may be narrower than a clk period, so it is turned into a level change.
  always_ff @(posedge i_drive or posedge rst) begin
    if (rst) tog_q <= 1'b0;
    else     tog_q <= ~tog_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tog_q;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign evt = s2_q ^ s3_q;
  assign pop = valid_q & i_ready;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    push     = 1'b0;
    // Occupancy after this edge; count < depth in IDLE so this cannot underflow or overflow.
    post_cnt = {1'b0, count_q} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};
    case (state_q)
      IDLE: begin
        if (evt) begin
          push   = 1'b1;
          fcnt_d = FW'(1);
          if (post_cnt < DEPTH_X) state_d = FREE;
          else                    state_d = WAIT_SPACE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_SPACE: begin
        if (pop) begin
          state_d = FREE;
          fcnt_d  = FW'(1);
        end else begin
          state_d = WAIT_SPACE;
        end
      end
      FREE: begin
        if (fcnt_q == FREE_LAST) state_d = IDLE;
        else                     fcnt_d  = fcnt_q + FW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (evt && (state_q != IDLE)) err_d = 1'b1;
    else                          err_d = err_q;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fcnt_q   <= FW'(0);
      err_q    <= 1'b0;
      count_q  <= CW'(0);
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      valid_q  <= 1'b0;
      free_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
      count_q  <= count_d;
      valid_q  <= (count_d != CW'(0));
      free_q   <= (state_d == FREE);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Payload is quasi-static by protocol, so it is sampled directly in the evt cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_free      = free_q;
  assign o_valid     = valid_q;
  assign o_data      = mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_proto_err = err_q;
endmodule
